// File: rtl/shifter_seq_ctrl_if.sv
// Handshake and operand bundle between the issue stage and the shifter-operand sequencer.
interface shifter_seq_ctrl_if;
  logic        start;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] rm_value;
  logic [7:0]  rs_value;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  modport master (
    output start, flush, instr, rm_value, rs_value, c_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, flush, instr, rm_value, rs_value, c_in,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/shifter_seq_ctrl.sv
// Sequential shifter-operand / address-offset generator: decodes the instruction at start,
// then shifts one bit per cycle and presents result and carry with a one-cycle done pulse.
module shifter_seq_ctrl (
  input logic               clk,
  input logic               reset_n,
  shifter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROR = 3'd3,
    OP_RRX = 3'd4
  } op_e;

  // One engine step; returns {shifted-out carry, new working word}.
  function automatic logic [32:0] shift_step(input logic [31:0] w, input op_e op,
                                             input logic rrx_in);
    logic [32:0] r;
    case (op)
      OP_LSL:  r = {w[31], w[30:0], 1'b0};
      OP_LSR:  r = {w[0], 1'b0, w[31:1]};
      OP_ASR:  r = {w[0], w[31], w[31:1]};
      OP_ROR:  r = {w[0], w[0], w[31:1]};
      OP_RRX:  r = {w[0], rrx_in, w[31:1]};
      default: r = {1'b0, w};
    endcase
    return r;
  endfunction

  state_e      state_r;
  op_e         op_r;
  logic [31:0] w_r;
  logic [5:0]  n_r;
  logic        cin_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;
  logic        carry_r;

  logic [31:0] dec_w_s;
  op_e         dec_op_s;
  logic [5:0]  dec_n_s;
  logic [31:0] dec_res_s;
  logic        dec_carry_s;
  logic [32:0] step_s;
  logic [2:0]  kind_s;
  logic [4:0]  imm_amt_s;
  logic [7:0]  rs_s;
  logic        unused_s;

  assign kind_s    = bus.instr[27:25];
  assign imm_amt_s = bus.instr[11:7];
  assign rs_s      = bus.rs_value;
  assign step_s    = shift_step(w_r, op_r, cin_r);
  assign unused_s  = ^{bus.instr[31:28], bus.instr[24:12]};

  // Instruction decode: initial working word, operation, step count, and the
  // result/carry used directly when no shifting is needed (N = 0).
  always_comb begin
    dec_w_s     = bus.rm_value;
    dec_op_s    = OP_LSL;
    dec_n_s     = 6'd0;
    dec_res_s   = 32'd0;
    dec_carry_s = bus.c_in;
    case (kind_s)
      3'b001: begin
        dec_w_s   = {24'd0, bus.instr[7:0]};
        dec_op_s  = OP_ROR;
        dec_n_s   = {1'b0, bus.instr[11:8], 1'b0};
        dec_res_s = {24'd0, bus.instr[7:0]};
      end
      3'b000, 3'b011: begin
        if (!bus.instr[4]) begin
          dec_res_s = bus.rm_value;
          if ((kind_s == 3'b011) && (bus.instr[11:4] == 8'd0)) begin
            dec_n_s = 6'd0;
          end else begin
            case (bus.instr[6:5])
              2'b00: begin
                dec_op_s = OP_LSL;
                dec_n_s  = {1'b0, imm_amt_s};
              end
              2'b01: begin
                dec_op_s = OP_LSR;
                dec_n_s  = (imm_amt_s == 5'd0) ? 6'd32 : {1'b0, imm_amt_s};
              end
              2'b10: begin
                dec_op_s = OP_ASR;
                dec_n_s  = (imm_amt_s == 5'd0) ? 6'd32 : {1'b0, imm_amt_s};
              end
              default: begin
                dec_op_s = (imm_amt_s == 5'd0) ? OP_RRX : OP_ROR;
                dec_n_s  = (imm_amt_s == 5'd0) ? 6'd1 : {1'b0, imm_amt_s};
              end
            endcase
          end
        end else if (kind_s == 3'b000) begin
          dec_res_s = bus.rm_value;
          if (rs_s == 8'd0) begin
            dec_n_s = 6'd0;
          end else begin
            case (bus.instr[6:5])
              2'b00: begin
                dec_op_s = OP_LSL;
                dec_n_s  = (rs_s > 8'd33) ? 6'd33 : rs_s[5:0];
              end
              2'b01: begin
                dec_op_s = OP_LSR;
                dec_n_s  = (rs_s > 8'd33) ? 6'd33 : rs_s[5:0];
              end
              2'b10: begin
                dec_op_s = OP_ASR;
                dec_n_s  = (rs_s > 8'd32) ? 6'd32 : rs_s[5:0];
              end
              default: begin
                dec_op_s = OP_ROR;
                dec_n_s  = {1'b0, rs_s[4:0]};
                if (rs_s[4:0] == 5'd0) begin
                  dec_carry_s = bus.rm_value[31];
                end else begin
                  dec_carry_s = bus.c_in;
                end
              end
            endcase
          end
        end else begin
          dec_res_s = 32'd0;
        end
      end
      3'b010: begin
        dec_res_s = {20'd0, bus.instr[11:0]};
      end
      default: begin
        dec_res_s = 32'd0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, result and carry outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_LSL;
      w_r      <= 32'd0;
      n_r      <= 6'd0;
      cin_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
      carry_r  <= 1'b0;
    end else if (bus.flush) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            w_r    <= dec_w_s;
            op_r   <= dec_op_s;
            n_r    <= dec_n_s;
            cin_r  <= bus.c_in;
            busy_r <= 1'b1;
            if (dec_n_s == 6'd0) begin
              state_r  <= ST_DONE;
              done_r   <= 1'b1;
              result_r <= dec_res_s;
              carry_r  <= dec_carry_s;
            end else begin
              state_r <= ST_SHIFT;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          w_r <= step_s[31:0];
          n_r <= n_r - 6'd1;
          if (n_r == 6'd1) begin
            state_r  <= ST_DONE;
            done_r   <= 1'b1;
            result_r <= step_s[31:0];
            carry_r  <= step_s[32];
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_r;

endmodule

// File: tb/tb_shifter_seq_ctrl.sv
// Self-checking bench for shifter_seq_ctrl: directed plan cases, abort paths, back-to-back
// handshake and randomized operations against an arithmetic reference model.
module tb_shifter_seq_ctrl;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  shifter_seq_ctrl_if bus ();

  shifter_seq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift primitives built from plain wide arithmetic.
  task automatic m_lsl(input logic [31:0] x, input int n, output logic [31:0] r, output logic c);
    logic [64:0] v;
    v = {33'd0, x} << n;
    r = v[31:0];
    c = v[32];
  endtask

  task automatic m_lsr(input logic [31:0] x, input int n, output logic [31:0] r, output logic c);
    logic [32:0] v;
    v = {x, 1'b0} >> n;
    r = v[32:1];
    c = v[0];
  endtask

  task automatic m_asr(input logic [31:0] x, input int n, output logic [31:0] r, output logic c);
    logic signed [32:0] v;
    v = $signed({x, 1'b0}) >>> n;
    r = v[32:1];
    c = v[0];
  endtask

  task automatic m_ror(input logic [31:0] x, input int n, output logic [31:0] r, output logic c);
    logic [63:0] v;
    v = {x, x} >> n;
    r = v[31:0];
    c = r[31];
  endtask

  task automatic ref_model(input logic [31:0] ins, input logic [31:0] rm, input logic [7:0] rs,
                           input logic cin, output logic [31:0] res, output logic co,
                           output int n);
    logic [2:0] kind;
    int amt;
    kind = ins[27:25];
    res = 32'd0;
    co = cin;
    n = 0;
    if (kind == 3'b001) begin
      n = 2 * int'(ins[11:8]);
      m_ror({24'd0, ins[7:0]}, n, res, co);
      if (n == 0) co = cin;
    end else if ((kind == 3'b000 || kind == 3'b011) && !ins[4]) begin
      amt = int'(ins[11:7]);
      res = rm;
      if (kind == 3'b011 && ins[11:4] == 8'd0) begin
        n = 0;
      end else begin
        case (ins[6:5])
          2'b00: begin n = amt; if (n > 0) m_lsl(rm, n, res, co); end
          2'b01: begin n = (amt == 0) ? 32 : amt; m_lsr(rm, n, res, co); end
          2'b10: begin n = (amt == 0) ? 32 : amt; m_asr(rm, n, res, co); end
          default: begin
            if (amt == 0) begin
              n = 1; res = {cin, rm[31:1]}; co = rm[0];
            end else begin
              n = amt; m_ror(rm, n, res, co);
            end
          end
        endcase
      end
    end else if (kind == 3'b000 && ins[4]) begin
      amt = int'(rs);
      res = rm;
      if (amt != 0) begin
        case (ins[6:5])
          2'b00: begin n = (amt > 33) ? 33 : amt; m_lsl(rm, n, res, co); end
          2'b01: begin n = (amt > 33) ? 33 : amt; m_lsr(rm, n, res, co); end
          2'b10: begin n = (amt > 32) ? 32 : amt; m_asr(rm, n, res, co); end
          default: begin
            n = amt % 32;
            if (n == 0) co = rm[31];
            else m_ror(rm, n, res, co);
          end
        endcase
      end
    end else if (kind == 3'b010) begin
      res = {20'd0, ins[11:0]};
    end else begin
      res = 32'd0;
    end
  endtask

  // Issues one start pulse and waits (bounded) for done; reports latency and the cycle after.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] rm, input logic [7:0] rs,
                        input logic cin, output int lat, output logic [31:0] res,
                        output logic co, output logic busy_ok, output logic tail_ok);
    int c;
    bus.instr = ins; bus.rm_value = rm; bus.rs_value = rs; bus.c_in = cin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_ok = 1'b1; res = 32'd0; co = 1'b0; c = 1;
    while (lat == 0 && c <= 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = c; res = bus.result; co = bus.carry_out;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    @(posedge clk); #1;
    tail_ok = (bus.done === 1'b0) && (bus.busy === 1'b0) &&
              (bus.result === res) && (bus.carry_out === co);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b result=%h carry=%b, want all zero",
               bus.busy, bus.done, bus.result, bus.carry_out);
    end
  endtask

  task automatic test_directed();
    logic [31:0] t_ins [5]  = '{32'h020004FF, 32'h00000200, 32'h00000060, 32'h00000030, 32'h04000ABC};
    logic [31:0] t_rm  [5]  = '{32'h0, 32'h8000000F, 32'h00000001, 32'hFFFFFFFF, 32'h0};
    logic [7:0]  t_rs  [5]  = '{8'd0, 8'd0, 8'd0, 8'd40, 8'd0};
    logic        t_cin [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_res [5]  = '{32'hFF000000, 32'h000000F0, 32'h80000000, 32'h0, 32'h00000ABC};
    logic        e_co  [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          e_lat [5]  = '{9, 5, 2, 34, 1};
    int lat; logic [31:0] res; logic co, bok, tok;
    for (int i = 0; i < 5; i++) begin
      run_op(t_ins[i], t_rm[i], t_rs[i], t_cin[i], lat, res, co, bok, tok);
      n_cmp++;
      if (lat !== e_lat[i] || res !== e_res[i] || co !== e_co[i] || !bok || !tok) begin
        n_bad++;
        $display("FAIL directed[%0d]: lat=%0d res=%h co=%b busy_ok=%b tail_ok=%b, want lat=%0d res=%h co=%b",
                 i, lat, res, co, bok, tok, e_lat[i], e_res[i], e_co[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int lat; int c;
    bus.instr = 32'h00000030; bus.rm_value = 32'hFFFFFFFF; bus.rs_value = 8'd40; bus.c_in = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; c = 1;
    while (lat == 0 && c <= 40) begin
      if (c == 5) begin bus.start = 1'b1; bus.instr = 32'h04000ABC; end
      if (c == 6) bus.start = 1'b0;
      if (bus.done === 1'b1) lat = c;
      else begin @(posedge clk); #1; c++; end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (lat != 34 || bus.result !== 32'd0 || bus.carry_out !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start: lat=%0d res=%h co=%b, want lat=34 res=00000000 co=0",
               lat, bus.result, bus.carry_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; logic co, bok, tok; int seen;
    run_op(32'h04000ABC, 32'h0, 8'd0, 1'b1, lat, res, co, bok, tok);
    bus.instr = 32'h00000020; bus.rm_value = 32'h12345678; bus.c_in = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h00000ABC || bus.carry_out !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_abort: busy=%b done=%b res=%h co=%b, want busy=0 done=0 res=00000abc co=1",
               bus.busy, bus.done, bus.result, bus.carry_out);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) seen++; end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL flush_no_done: active cycles after flush=%0d, want 0", seen);
    end
    bus.instr = 32'h04000123; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h00000ABC) begin
      n_bad++;
      $display("FAIL flush_wins: busy=%b done=%b res=%h, want busy=0 done=0 res=00000abc",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid();
    bus.instr = 32'h00000020; bus.rm_value = 32'hDEADBEEF; bus.c_in = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_busy: busy=%b, want 1", bus.busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b res=%h co=%b, want all zero",
               bus.busy, bus.done, bus.result, bus.carry_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] pat;
    bus.instr = 32'h04000555; bus.c_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; pat[2] = bus.done;
    @(posedge clk); #1; pat[1] = bus.done;
    @(posedge clk); #1; pat[0] = bus.done;
    bus.start = 1'b0;
    n_cmp++;
    if (pat !== 3'b101 || bus.result !== 32'h00000555) begin
      n_bad++;
      $display("FAIL back_to_back: done pattern=%b res=%h, want 101 res=00000555", pat, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] ins, rm, e_res, res;
    logic [7:0]  rs;
    logic        cin, e_co, co, bok, tok;
    int          e_n, lat, e_lat;
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[27:25] = 3'b000;
        1: ins[27:25] = 3'b001;
        2: ins[27:25] = 3'b010;
        3: ins[27:25] = 3'b011;
        4: begin ins[27:25] = 3'b000; ins[4] = 1'b1; end
        default: ins[27:25] = 3'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      rm = $urandom;
      case ($urandom_range(0, 5))
        0: rs = 8'd0;
        1: rs = 8'd32;
        2: rs = 8'd33;
        3: rs = 8'd64;
        default: rs = 8'($urandom);
      endcase
      cin = 1'($urandom);
      ref_model(ins, rm, rs, cin, e_res, e_co, e_n);
      e_lat = (e_n == 0) ? 1 : e_n + 1;
      run_op(ins, rm, rs, cin, lat, res, co, bok, tok);
      n_cmp++;
      if (lat != e_lat || res !== e_res || co !== e_co || !bok || !tok) begin
        n_bad++;
        $display("FAIL random[%0d] instr=%h rm=%h rs=%0d cin=%b: lat=%0d res=%h co=%b busy_ok=%b tail_ok=%b, want lat=%0d res=%h co=%b",
                 i, ins, rm, rs, cin, lat, res, co, bok, tok, e_lat, e_res, e_co);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.instr = 32'd0;
    bus.rm_value = 32'd0; bus.rs_value = 8'd0; bus.c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_ignored_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
